exc_commit_ctrl: RTL and testbench
==================================

Name: exc_commit_ctrl

Overview:
- Writeback-side initiator of the exception/return/refetch/idle protocol consumed by the CSR unit.
- Collects per-instruction exception flags carried down the pipeline and samples interrupt state from the CSR. It prioritises and encodes one event per cycle, drives the registered event strobes to the CSR, and gates retirement.
- Holds the pipeline flushed until the CSR answers with exlike, and owns the idle-wait state.

Parameters:
ADDR_W, 32, width of pc and bad virtual address
INT_W, 12, number of interrupt lines (lie/is width)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
wb_valid  in  1  valid instruction present in WB
wb_pc  in  ADDR_W  pc of WB instruction
wb_exc_vec  in  15  exception flags, bit order: 0 ADEF, 1 TLBR_F, 2 PIF, 3 PPI_F, 4 INE, 5 IPE, 6 SYS, 7 BRK, 8 ADEM, 9 ALE, 10 TLBR_M, 11 PIL, 12 PIS, 13 PPI_M, 14 PME
wb_badv_m  in  ADDR_W  memory-stage virtual address
wb_is_ertn  in  1  WB instruction is ertn
wb_is_refetch  in  1  WB instruction requires pc+4 refetch (tlb instrs, cacop)
wb_is_idle  in  1  WB instruction is idle
ie  in  1  CRMD.IE from CSR
lie  in  INT_W  ECFG.LIE from CSR
is  in  INT_W  ESTAT.IS from CSR
exlike  in  1  CSR redirect acknowledge, registered one cycle after an event strobe
is_exc  out  1  exception strobe to CSR
excode  out  6  exception code
esubcode  out  9  exception subcode
badvaddr  out  ADDR_W  bad virtual address
csr_pc  out  ADDR_W  pc for ERA / refetch
is_ertn  out  1  ertn strobe
is_fetch_again  out  1  refetch strobe
is_idle  out  1  idle strobe
commit  out  1  WB instruction retires (register/memory side effects allowed)
flush  out  1  kill all younger pipeline contents
wb_stall  out  1  hold WB (idle wait)

Behaviour:
- Reset: all outputs 0; state RUN.
- int_pend = ie & |(lie & is).
- Encoding, fixed priority, first match wins:
  - interrupt (INT=0x00)
  - ADEF (0x08, sub 0)
  - TLBR_F (0x3F)
  - PIF (0x03)
  - PPI_F (0x07)
  - INE (0x0D)
  - IPE (0x0E)
  - SYS (0x0B)
  - BRK (0x0C)
  - ADEM (0x08, sub 1)
  - ALE (0x09)
  - TLBR_M (0x3F)
  - PIL (0x01)
  - PIS (0x02)
  - PPI_M (0x07)
  - PME (0x04)
- esubcode is 0 except ADEM (=1).
- badvaddr: wb_pc for fetch-stage causes (bits 0-3), wb_badv_m for bits 8-14, 0 otherwise.
- States:
  - RUN: with wb_valid, evaluate in the order exception > ertn > refetch > idle > normal. Any event registers its single strobe plus payload, csr_pc <= wb_pc.
    - Exception, ertn or refetch: assert flush combinationally this cycle, commit=0 for exceptions (ertn/refetch/idle do commit=1), go to WAIT.
    - Idle: commit=1, strobe is_idle, flush=1, go to IDLE.
    - Normal instruction: commit=1, no strobe.
    - int_pend with wb_valid=0: no action, the interrupt waits for the next valid instruction.
  - WAIT: flush=1, commit=0, strobes 0. On exlike=1 go to RUN. No cycle limit.
  - IDLE: wb_stall=1, flush=1, commit=0.
    - On int_pend: strobe is_exc with excode INT, go to WAIT. csr_pc carries the idle pc; the CSR forms ERA.
    - Other WB inputs are ignored.
- Strobe timing: strobes and payload are registered, a one-cycle pulse at t+1 for a WB event at t. exlike is expected at t+2.
- Mutual exclusion: at most one of is_exc/is_ertn/is_fetch_again/is_idle is high in any cycle.
- Idle between strobes: excode, esubcode and badvaddr are driven 0 whenever is_exc=0. This prevents the CSR selecting TLBRENTRY for a following ertn.
- Simultaneous events: an exception flag on an ertn, refetch or idle instruction takes the exception path. A new event is never issued while in WAIT.
- An exlike observed in RUN or IDLE is ignored.
- Reset mid-WAIT or mid-IDLE returns to RUN with all strobes 0 in the next cycle.

Test Plan:
- Exception path: wb_valid, pc=0x1c000100, vec bit 6 (SYS).
  - Next cycle: is_exc=1, excode=0x0B, esubcode=0, csr_pc=0x1c000100.
  - flush=1 until exlike. commit=0.
- Priority: vec bits 0 and 9 set, pc=0x1c000200 -> excode=0x08, esubcode=0, badvaddr=0x1c000200.
- Memory bad address: vec bits 8 and 10 with badv_m=0x8000_0004 -> excode=0x08, esubcode=1, badvaddr=0x8000_0004.
  - Then vec bit 10 only -> excode=0x3F.
  - Then an ertn -> excode=0 on the is_ertn cycle.
- Interrupt vs commit: ie=1, lie=0x800, is=0x800 with a normal WB instruction -> is_exc excode=0x00, commit=0.
  - Repeat with ie=0 -> commit=1, no strobe.
- Idle wake: idle at pc 0x1c000300 -> is_idle pulse, wb_stall held.
  - Raise is[11] with lie[11]=1, ie=1 after 20 cycles -> is_exc INT, state WAIT, exlike returns to RUN.
- Refetch and reset: refetch at pc 0x1c000400 -> is_fetch_again=1, csr_pc=0x1c000400, commit=1.
  - Assert reset in WAIT -> all outputs 0 next cycle, a subsequent normal instruction commits.

Source files
------------

// File: rtl/exc_commit_ctrl.sv
// Writeback-side exception/ertn/refetch/idle initiator toward the CSR unit.
// Prioritises one event per cycle, registers the strobes, and gates retirement.
module exc_commit_ctrl #(
    parameter int ADDR_W = 32,
    parameter int INT_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_pc,
    input  logic [14:0]       wb_exc_vec,
    input  logic [ADDR_W-1:0] wb_badv_m,
    input  logic              wb_is_ertn,
    input  logic              wb_is_refetch,
    input  logic              wb_is_idle,
    input  logic              ie,
    input  logic [INT_W-1:0]  lie,
    input  logic [INT_W-1:0]  is,
    input  logic              exlike,
    output logic              is_exc,
    output logic [5:0]        excode,
    output logic [8:0]        esubcode,
    output logic [ADDR_W-1:0] badvaddr,
    output logic [ADDR_W-1:0] csr_pc,
    output logic              is_ertn,
    output logic              is_fetch_again,
    output logic              is_idle,
    output logic              commit,
    output logic              flush,
    output logic              wb_stall
);

    // state  | meaning
    // S_RUN  | normal retirement, events evaluated on each valid WB instruction
    // S_WAIT | event issued, pipeline held flushed until CSR answers with exlike
    // S_IDLE | idle retired, WB stalled until an interrupt becomes pending
    typedef enum logic [1:0] {S_RUN, S_WAIT, S_IDLE} state_t;

    state_t            state, state_nxt;
    logic              int_pend;
    logic              any_exc;
    logic [5:0]        enc_code;
    logic [8:0]        enc_sub;
    logic [ADDR_W-1:0] enc_badv;

    logic              exc_nxt, ertn_nxt, fa_nxt, idle_nxt;
    logic [5:0]        code_nxt;
    logic [8:0]        sub_nxt;
    logic [ADDR_W-1:0] badv_nxt, pc_nxt;
    logic              commit_c, flush_c, stall_c;

    assign int_pend = ie & (|(lie & is));
    assign any_exc  = int_pend | (|wb_exc_vec);

    always_comb begin
        enc_code = 6'h00;
        enc_sub  = 9'd0;
        enc_badv = '0;
        if (int_pend)           enc_code = 6'h00;
        else if (wb_exc_vec[0]) begin enc_code = 6'h08; enc_badv = wb_pc; end
        else if (wb_exc_vec[1]) begin enc_code = 6'h3F; enc_badv = wb_pc; end
        else if (wb_exc_vec[2]) begin enc_code = 6'h03; enc_badv = wb_pc; end
        else if (wb_exc_vec[3]) begin enc_code = 6'h07; enc_badv = wb_pc; end
        else if (wb_exc_vec[4]) enc_code = 6'h0D;
        else if (wb_exc_vec[5]) enc_code = 6'h0E;
        else if (wb_exc_vec[6]) enc_code = 6'h0B;
        else if (wb_exc_vec[7]) enc_code = 6'h0C;
        else if (wb_exc_vec[8]) begin
            enc_code = 6'h08;
            enc_sub  = 9'd1;
            enc_badv = wb_badv_m;
        end
        else if (wb_exc_vec[9])  begin enc_code = 6'h09; enc_badv = wb_badv_m; end
        else if (wb_exc_vec[10]) begin enc_code = 6'h3F; enc_badv = wb_badv_m; end
        else if (wb_exc_vec[11]) begin enc_code = 6'h01; enc_badv = wb_badv_m; end
        else if (wb_exc_vec[12]) begin enc_code = 6'h02; enc_badv = wb_badv_m; end
        else if (wb_exc_vec[13]) begin enc_code = 6'h07; enc_badv = wb_badv_m; end
        else if (wb_exc_vec[14]) begin enc_code = 6'h04; enc_badv = wb_badv_m; end
    end

    always_comb begin
        state_nxt = state;
        exc_nxt   = 1'b0;
        ertn_nxt  = 1'b0;
        fa_nxt    = 1'b0;
        idle_nxt  = 1'b0;
        code_nxt  = 6'h00;
        sub_nxt   = 9'd0;
        badv_nxt  = '0;
        pc_nxt    = csr_pc;
        commit_c  = 1'b0;
        flush_c   = 1'b0;
        stall_c   = 1'b0;
        case (state)
            S_RUN: begin
                if (wb_valid) begin
                    if (any_exc) begin
                        exc_nxt   = 1'b1;
                        code_nxt  = enc_code;
                        sub_nxt   = enc_sub;
                        badv_nxt  = enc_badv;
                        pc_nxt    = wb_pc;
                        flush_c   = 1'b1;
                        state_nxt = S_WAIT;
                    end else if (wb_is_ertn || wb_is_refetch) begin
                        ertn_nxt  = wb_is_ertn;
                        fa_nxt    = ~wb_is_ertn;
                        pc_nxt    = wb_pc;
                        commit_c  = 1'b1;
                        flush_c   = 1'b1;
                        state_nxt = S_WAIT;
                    end else if (wb_is_idle) begin
                        idle_nxt  = 1'b1;
                        pc_nxt    = wb_pc;
                        commit_c  = 1'b1;
                        flush_c   = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        commit_c  = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                flush_c = 1'b1;
                if (exlike) state_nxt = S_RUN;
            end
            S_IDLE: begin
                stall_c = 1'b1;
                flush_c = 1'b1;
                // csr_pc still holds the idle pc; the CSR derives ERA from it
                if (int_pend) begin
                    exc_nxt   = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            default: state_nxt = S_RUN;
        endcase
    end

    assign commit   = commit_c & ~reset;
    assign flush    = flush_c  & ~reset;
    assign wb_stall = stall_c  & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_RUN;
            is_exc         <= 1'b0;
            is_ertn        <= 1'b0;
            is_fetch_again <= 1'b0;
            is_idle        <= 1'b0;
            excode         <= 6'h00;
            esubcode       <= 9'd0;
            badvaddr       <= '0;
            csr_pc         <= '0;
        end else begin
            state          <= state_nxt;
            is_exc         <= exc_nxt;
            is_ertn        <= ertn_nxt;
            is_fetch_again <= fa_nxt;
            is_idle        <= idle_nxt;
            excode         <= code_nxt;
            esubcode       <= sub_nxt;
            badvaddr       <= badv_nxt;
            csr_pc         <= pc_nxt;
        end
    end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Directed self-checking bench for exc_commit_ctrl.
module tb_exc_commit_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [14:0] wb_exc_vec;
    logic [31:0] wb_badv_m;
    logic        wb_is_ertn, wb_is_refetch, wb_is_idle;
    logic        ie;
    logic [11:0] lie, is;
    logic        exlike;
    logic        is_exc;
    logic [5:0]  excode;
    logic [8:0]  esubcode;
    logic [31:0] badvaddr, csr_pc;
    logic        is_ertn, is_fetch_again, is_idle;
    logic        commit, flush, wb_stall;

    int n_checks = 0;
    int n_fail   = 0;

    exc_commit_ctrl #(.ADDR_W(32), .INT_W(12)) dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_exc_vec(wb_exc_vec), .wb_badv_m(wb_badv_m), .wb_is_ertn(wb_is_ertn),
        .wb_is_refetch(wb_is_refetch), .wb_is_idle(wb_is_idle), .ie(ie), .lie(lie),
        .is(is), .exlike(exlike), .is_exc(is_exc), .excode(excode), .esubcode(esubcode),
        .badvaddr(badvaddr), .csr_pc(csr_pc), .is_ertn(is_ertn),
        .is_fetch_again(is_fetch_again), .is_idle(is_idle), .commit(commit),
        .flush(flush), .wb_stall(wb_stall)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_wb();
        wb_valid      = 1'b0;
        wb_pc         = 32'h0;
        wb_exc_vec    = 15'h0;
        wb_badv_m     = 32'h0;
        wb_is_ertn    = 1'b0;
        wb_is_refetch = 1'b0;
        wb_is_idle    = 1'b0;
        exlike        = 1'b0;
    endtask

    task automatic finish_wait();
        exlike = 1'b1;
        step();
        exlike = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_wb();
        ie = 1'b0; lie = 12'h0; is = 12'h0;
        step(); step();
        n_checks++;
        if ({is_exc, is_ertn, is_fetch_again, is_idle, commit, flush, wb_stall} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b exp 0000000",
                     {is_exc, is_ertn, is_fetch_again, is_idle, commit, flush, wb_stall});
        end
        n_checks++;
        if ({excode, esubcode, badvaddr, csr_pc} !== 79'h0) begin
            n_fail++;
            $display("FAIL reset_payload: excode %h esub %h badv %h pc %h exp all 0",
                     excode, esubcode, badvaddr, csr_pc);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_exception();
        wb_valid = 1'b1; wb_pc = 32'h1c000100; wb_exc_vec = 15'h0040;
        #1;
        n_checks++;
        if ({commit, flush} !== 2'b01) begin
            n_fail++; $display("FAIL sys_comb: commit,flush got %b exp 01", {commit, flush});
        end
        step();
        clear_wb();
        n_checks++;
        if ({is_exc, excode, esubcode, csr_pc, badvaddr} !== {1'b1, 6'h0B, 9'd0, 32'h1c000100, 32'h0}) begin
            n_fail++;
            $display("FAIL sys_strobe: exc %b code %h sub %h pc %h badv %h exp 1 0b 0 1c000100 0",
                     is_exc, excode, esubcode, csr_pc, badvaddr);
        end
        // a new event attempted in WAIT must not be issued
        wb_valid = 1'b1; wb_pc = 32'h1c000104; wb_exc_vec = 15'h0040;
        #1;
        n_checks++;
        if ({commit, flush} !== 2'b01) begin
            n_fail++; $display("FAIL wait_hold: commit,flush got %b exp 01", {commit, flush});
        end
        step();
        clear_wb();
        n_checks++;
        if ({is_exc, is_ertn, is_fetch_again, is_idle, flush} !== 5'b00001) begin
            n_fail++;
            $display("FAIL wait_no_event: strobes,flush got %b exp 00001",
                     {is_exc, is_ertn, is_fetch_again, is_idle, flush});
        end
        finish_wait();
        n_checks++;
        if ({flush, commit} !== 2'b00) begin
            n_fail++; $display("FAIL exlike_run: flush,commit got %b exp 00", {flush, commit});
        end
    endtask

    task automatic test_priority();
        wb_valid = 1'b1; wb_pc = 32'h1c000200; wb_exc_vec = 15'h0201; wb_badv_m = 32'hdead0000;
        step();
        clear_wb();
        n_checks++;
        if ({is_exc, excode, esubcode, badvaddr} !== {1'b1, 6'h08, 9'd0, 32'h1c000200}) begin
            n_fail++;
            $display("FAIL prio_adef: exc %b code %h sub %h badv %h exp 1 08 0 1c000200",
                     is_exc, excode, esubcode, badvaddr);
        end
        finish_wait();
    endtask

    task automatic test_badaddr();
        wb_valid = 1'b1; wb_pc = 32'h1c000210; wb_exc_vec = 15'h0500; wb_badv_m = 32'h80000004;
        step();
        clear_wb();
        n_checks++;
        if ({excode, esubcode, badvaddr} !== {6'h08, 9'd1, 32'h80000004}) begin
            n_fail++;
            $display("FAIL adem: code %h sub %h badv %h exp 08 1 80000004", excode, esubcode, badvaddr);
        end
        finish_wait();
        wb_valid = 1'b1; wb_pc = 32'h1c000214; wb_exc_vec = 15'h0400; wb_badv_m = 32'h80000004;
        step();
        clear_wb();
        n_checks++;
        if ({is_exc, excode, esubcode, badvaddr} !== {1'b1, 6'h3F, 9'd0, 32'h80000004}) begin
            n_fail++;
            $display("FAIL tlbr_m: exc %b code %h sub %h badv %h exp 1 3f 0 80000004",
                     is_exc, excode, esubcode, badvaddr);
        end
        finish_wait();
        wb_valid = 1'b1; wb_pc = 32'h1c000500; wb_is_ertn = 1'b1;
        #1;
        n_checks++;
        if ({commit, flush} !== 2'b11) begin
            n_fail++; $display("FAIL ertn_comb: commit,flush got %b exp 11", {commit, flush});
        end
        step();
        clear_wb();
        n_checks++;
        if ({is_ertn, is_exc, excode, esubcode, badvaddr, csr_pc} !==
            {1'b1, 1'b0, 6'h00, 9'd0, 32'h0, 32'h1c000500}) begin
            n_fail++;
            $display("FAIL ertn_strobe: ertn %b exc %b code %h sub %h badv %h pc %h exp 1 0 00 0 0 1c000500",
                     is_ertn, is_exc, excode, esubcode, badvaddr, csr_pc);
        end
        finish_wait();
    endtask

    task automatic test_simultaneous();
        wb_valid = 1'b1; wb_pc = 32'h1c000510; wb_is_ertn = 1'b1; wb_exc_vec = 15'h0080;
        #1;
        n_checks++;
        if (commit !== 1'b0) begin
            n_fail++; $display("FAIL brk_on_ertn_commit: got %b exp 0", commit);
        end
        step();
        clear_wb();
        n_checks++;
        if ({is_exc, is_ertn, excode} !== {1'b1, 1'b0, 6'h0C}) begin
            n_fail++;
            $display("FAIL brk_on_ertn: exc %b ertn %b code %h exp 1 0 0c", is_exc, is_ertn, excode);
        end
        finish_wait();
    endtask

    task automatic test_interrupt();
        ie = 1'b1; lie = 12'h800; is = 12'h800;
        step();
        n_checks++;
        if ({is_exc, commit, flush} !== 3'b000) begin
            n_fail++; $display("FAIL int_no_valid: exc,commit,flush got %b exp 000", {is_exc, commit, flush});
        end
        wb_valid = 1'b1; wb_pc = 32'h1c000600;
        #1;
        n_checks++;
        if ({commit, flush} !== 2'b01) begin
            n_fail++; $display("FAIL int_comb: commit,flush got %b exp 01", {commit, flush});
        end
        step();
        clear_wb();
        n_checks++;
        if ({is_exc, excode, csr_pc, badvaddr} !== {1'b1, 6'h00, 32'h1c000600, 32'h0}) begin
            n_fail++;
            $display("FAIL int_strobe: exc %b code %h pc %h badv %h exp 1 00 1c000600 0",
                     is_exc, excode, csr_pc, badvaddr);
        end
        finish_wait();
        ie = 1'b0;
        wb_valid = 1'b1; wb_pc = 32'h1c000604;
        #1;
        n_checks++;
        if ({commit, flush} !== 2'b10) begin
            n_fail++; $display("FAIL int_masked_comb: commit,flush got %b exp 10", {commit, flush});
        end
        step();
        clear_wb();
        n_checks++;
        if ({is_exc, is_ertn, is_fetch_again, is_idle} !== 4'b0000) begin
            n_fail++;
            $display("FAIL int_masked_strobe: got %b exp 0000", {is_exc, is_ertn, is_fetch_again, is_idle});
        end
        is = 12'h0;
    endtask

    task automatic test_idle();
        logic stall_all;
        logic strobe_seen;
        ie = 1'b0; lie = 12'h800; is = 12'h0;
        wb_valid = 1'b1; wb_pc = 32'h1c000300; wb_is_idle = 1'b1;
        #1;
        n_checks++;
        if ({commit, flush} !== 2'b11) begin
            n_fail++; $display("FAIL idle_comb: commit,flush got %b exp 11", {commit, flush});
        end
        step();
        clear_wb();
        n_checks++;
        if ({is_idle, is_exc, wb_stall, csr_pc} !== {1'b1, 1'b0, 1'b1, 32'h1c000300}) begin
            n_fail++;
            $display("FAIL idle_strobe: idle %b exc %b stall %b pc %h exp 1 0 1 1c000300",
                     is_idle, is_exc, wb_stall, csr_pc);
        end
        stall_all = 1'b1;
        strobe_seen = 1'b0;
        wb_valid = 1'b1; wb_pc = 32'h1c000304; wb_exc_vec = 15'h0040; exlike = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            stall_all   = stall_all & wb_stall & flush & ~commit;
            strobe_seen = strobe_seen | is_exc | is_ertn | is_fetch_again | is_idle;
        end
        clear_wb();
        n_checks++;
        if ({stall_all, strobe_seen} !== 2'b10) begin
            n_fail++;
            $display("FAIL idle_hold: stall_all %b strobe_seen %b exp 1 0", stall_all, strobe_seen);
        end
        ie = 1'b1; is = 12'h800;
        step();
        ie = 1'b0;
        n_checks++;
        if ({is_exc, excode, csr_pc, wb_stall, flush} !== {1'b1, 6'h00, 32'h1c000300, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL idle_wake: exc %b code %h pc %h stall %b flush %b exp 1 00 1c000300 0 1",
                     is_exc, excode, csr_pc, wb_stall, flush);
        end
        finish_wait();
        n_checks++;
        if ({flush, wb_stall} !== 2'b00) begin
            n_fail++; $display("FAIL idle_exit: flush,stall got %b exp 00", {flush, wb_stall});
        end
        is = 12'h0;
    endtask

    task automatic test_refetch_reset();
        wb_valid = 1'b1; wb_pc = 32'h1c000400; wb_is_refetch = 1'b1;
        #1;
        n_checks++;
        if ({commit, flush} !== 2'b11) begin
            n_fail++; $display("FAIL refetch_comb: commit,flush got %b exp 11", {commit, flush});
        end
        step();
        clear_wb();
        n_checks++;
        if ({is_fetch_again, is_exc, is_ertn, csr_pc} !== {1'b1, 1'b0, 1'b0, 32'h1c000400}) begin
            n_fail++;
            $display("FAIL refetch_strobe: fa %b exc %b ertn %b pc %h exp 1 0 0 1c000400",
                     is_fetch_again, is_exc, is_ertn, csr_pc);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        n_checks++;
        if ({is_exc, is_ertn, is_fetch_again, is_idle, commit, flush, wb_stall, csr_pc} !== 39'h0) begin
            n_fail++;
            $display("FAIL reset_in_wait: strobes %b pc %h exp 0",
                     {is_exc, is_ertn, is_fetch_again, is_idle, commit, flush, wb_stall}, csr_pc);
        end
        wb_valid = 1'b1; wb_pc = 32'h1c000700;
        #1;
        n_checks++;
        if ({commit, flush} !== 2'b10) begin
            n_fail++; $display("FAIL post_reset_commit: commit,flush got %b exp 10", {commit, flush});
        end
        step();
        clear_wb();
    endtask

    initial begin
        test_reset();
        test_exception();
        test_priority();
        test_badaddr();
        test_simultaneous();
        test_interrupt();
        test_idle();
        test_refetch_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
